jtgng_prog_buf: RTL and testbench

ROM-download write buffer between the frame's ioctl byte stream and the SDRAM controller's programming port. It accepts one byte per `ioctl_wr` pulse and converts the byte address into a word address plus byte mask. Each write is held on `prog_*` until the SDRAM controller acknowledges it, and a 4-entry FIFO absorbs ioctl bursts that arrive while a write is pending. It also reports overflow, accepted byte count and end of download.

---
 rtl/jtgng_prog_buf.sv | 154 +++++++++++++++
 tb/tb_jtgng_prog_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtgng_prog_buf.sv
// ROM-download write buffer: turns the ioctl byte stream into SDRAM word writes
// held until acknowledged, with a small FIFO to absorb bursts.
module jtgng_prog_buf #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter logic [21:0] OFFSET     = 22'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        sdram_ack,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        dl_done,
    output logic        overflow,
    output logic [21:0] byte_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    logic [21:0] mem_addr [DEPTH];
    logic [7:0]  mem_data [DEPTH];
    logic [1:0]  mem_mask [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push, pop, full, bypass;
    logic [21:0]           new_addr, head_addr;
    logic [7:0]            head_data;
    logic [1:0]            new_mask, head_mask;
    logic                  dl_prev_q, rise, fall;
    logic [1:0]            state_q, state_d;
    logic                  dl_done_d, overflow_d;
    logic [21:0]           byte_cnt_d;

    assign full     = (count_q == CNT_FULL);
    assign pop      = sdram_ack & prog_we;
    // A pop frees a slot in the same cycle, so a full FIFO can still take a byte.
    assign push     = ioctl_wr & (~full | pop);
    assign new_addr = {1'b0, ioctl_addr[21:1]} + OFFSET;
    assign new_mask = ioctl_addr[0] ? 2'b01 : 2'b10;
    assign rise     = downloading & ~dl_prev_q;
    assign fall     = ~downloading & dl_prev_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        // The incoming byte becomes the head when nothing else remains ahead of it.
        bypass = push & ((count_q == '0) | (pop & (count_q == CNT_ONE)));
        if (bypass) begin
            head_addr = new_addr;
            head_data = ioctl_data;
            head_mask = new_mask;
        end else begin
            head_addr = mem_addr[rd_ptr_d];
            head_data = mem_data[rd_ptr_d];
            head_mask = mem_mask[rd_ptr_d];
        end
    end

    always_comb begin
        byte_cnt_d = rise ? 22'd0 : byte_cnt;
        if (push) begin
            byte_cnt_d = byte_cnt_d + 22'd1;
        end
        overflow_d = (rise ? 1'b0 : overflow) | (ioctl_wr & ~push);
    end

    always_comb begin
        state_d   = state_q;
        dl_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) state_d = StLoad;
            end
            StLoad: begin
                if (fall) begin
                    if (count_d == '0) begin
                        state_d   = StIdle;
                        dl_done_d = 1'b1;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (rise) begin
                    state_d = StLoad;
                end else if (count_d == '0) begin
                    state_d   = StIdle;
                    dl_done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr_q] <= new_addr;
            mem_data[wr_ptr_q] <= ioctl_data;
            mem_mask[wr_ptr_q] <= new_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            prog_we   <= 1'b0;
            prog_addr <= 22'd0;
            prog_data <= 8'd0;
            prog_mask <= 2'b11;
            dl_prev_q <= 1'b0;
            state_q   <= StIdle;
            dl_done   <= 1'b0;
            overflow  <= 1'b0;
            byte_cnt  <= 22'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            prog_we   <= (count_d != '0);
            if (count_d != '0) begin
                prog_addr <= head_addr;
                prog_data <= head_data;
                prog_mask <= head_mask;
            end
            dl_prev_q <= downloading;
            state_q   <= state_d;
            dl_done   <= dl_done_d;
            overflow  <= overflow_d;
            byte_cnt  <= byte_cnt_d;
        end
    end

endmodule

// File: tb/tb_jtgng_prog_buf.sv
// Bench for jtgng_prog_buf: directed scenarios plus random traffic against a queue model.
module tb_jtgng_prog_buf;

    localparam logic [21:0] OFF1  = 22'h3FFFFF;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [21:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic        ioctl_wr = 1'b0;
    logic        sdram_ack = 1'b0;

    logic [21:0] o0_addr, o1_addr, o0_cnt, o1_cnt;
    logic [7:0]  o0_data, o1_data;
    logic [1:0]  o0_mask, o1_mask;
    logic        o0_we, o1_we, o0_done, o1_done, o0_ov, o1_ov;

    always #5 clk = ~clk;

    jtgng_prog_buf #(.DEPTH_LOG2(2), .OFFSET(22'd0)) dut0 (
        .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .sdram_ack(sdram_ack),
        .prog_addr(o0_addr), .prog_data(o0_data), .prog_mask(o0_mask), .prog_we(o0_we),
        .dl_done(o0_done), .overflow(o0_ov), .byte_cnt(o0_cnt)
    );

    jtgng_prog_buf #(.DEPTH_LOG2(2), .OFFSET(OFF1)) dut1 (
        .clk(clk), .rst(rst), .downloading(downloading), .ioctl_addr(ioctl_addr),
        .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr), .sdram_ack(sdram_ack),
        .prog_addr(o1_addr), .prog_data(o1_data), .prog_mask(o1_mask), .prog_we(o1_we),
        .dl_done(o1_done), .overflow(o1_ov), .byte_cnt(o1_cnt)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [21:0] a;
        logic [7:0]  d;
    } ent_t;

    ent_t q[$];
    int   m_cnt;
    bit   m_ov, m_prev, m_done;
    int   m_phase;  // 0 idle, 1 loading, 2 draining

    function automatic logic [21:0] waddr(input logic [21:0] a, input logic [21:0] off);
        return 22'((a >> 1) + off);
    endfunction

    function automatic logic [1:0] wmask(input logic [21:0] a);
        return a[0] ? 2'b01 : 2'b10;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cnt = 0; m_ov = 0; m_prev = 0; m_done = 0; m_phase = 0;
    endtask

    task automatic model_step(input bit wr, input logic [21:0] a, input logic [7:0] d,
                              input bit ack, input bit dl);
        bit pop, push, rise, fall;
        pop  = ack && q.size() != 0;
        push = wr && (q.size() < DEPTH || pop);
        rise = dl && !m_prev;
        fall = !dl && m_prev;
        m_prev = dl;
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{a: a, d: d});
        if (rise) begin
            m_cnt = 0;
            m_ov  = 0;
        end
        if (push) m_cnt = (m_cnt + 1) % (1 << 22);
        if (wr && !push) m_ov = 1;
        m_done = 0;
        if (m_phase == 0) begin
            if (rise) m_phase = 1;
        end else if (m_phase == 1) begin
            if (fall) begin
                if (q.size() == 0) begin
                    m_phase = 0;
                    m_done  = 1;
                end else m_phase = 2;
            end
        end else begin
            if (rise) m_phase = 1;
            else if (q.size() == 0) begin
                m_phase = 0;
                m_done  = 1;
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, settle 1 time unit.
    task automatic step(input bit wr, input logic [21:0] a, input logic [7:0] d,
                        input bit ack, input bit dl);
        ioctl_wr = wr; ioctl_addr = a; ioctl_data = d; sdram_ack = ack; downloading = dl;
        @(posedge clk);
        model_step(wr, a, d, ack, dl);
        #1;
        ioctl_wr = 1'b0; sdram_ack = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (o0_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", o0_we); end
        checks++; if (o0_addr !== 22'd0) begin errors++; $display("FAIL reset_addr: got %h want 0", o0_addr); end
        checks++; if (o0_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %h want 0", o0_data); end
        checks++; if (o0_mask !== 2'b11 || o1_mask !== 2'b11) begin errors++;
            $display("FAIL reset_mask: got %b/%b want 11", o0_mask, o1_mask); end
        checks++; if (o0_done !== 1'b0 || o0_ov !== 1'b0 || o0_cnt !== 22'd0) begin errors++;
            $display("FAIL reset_status: got done=%b ov=%b cnt=%h want 0", o0_done, o0_ov, o0_cnt); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        step(1, 22'h000005, 8'hA5, 0, 1);
        checks++; if (o0_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b want 1", o0_we); end
        checks++; if (o0_addr !== 22'h2 || o0_data !== 8'hA5 || o0_mask !== 2'b01) begin errors++;
            $display("FAIL single_entry: got %h/%h/%b want 000002/a5/01", o0_addr, o0_data, o0_mask); end
        checks++; if (o1_addr !== 22'h1) begin errors++; $display("FAIL single_off_addr: got %h want 000001", o1_addr); end
        step(0, 0, 0, 1, 1);
        checks++; if (o0_we !== 1'b0 || o0_cnt !== 22'd1) begin errors++;
            $display("FAIL single_ack: got we=%b cnt=%h want we=0 cnt=1", o0_we, o0_cnt); end
    endtask

    task automatic test_offset_wrap();
        step(1, 22'h000004, 8'h3C, 0, 1);
        checks++; if (o1_addr !== 22'h000001 || o1_mask !== 2'b10) begin errors++;
            $display("FAIL wrap_entry: got %h/%b want 000001/10", o1_addr, o1_mask); end
        checks++; if (o0_addr !== 22'h000002) begin errors++; $display("FAIL wrap_base: got %h want 000002", o0_addr); end
        step(0, 0, 0, 1, 1);
    endtask

    task automatic test_burst_overflow();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(1, 22'(i), 8'(i), 0, 1);
        checks++; if (o0_ov !== 1'b1 || o0_cnt !== 22'd4) begin errors++;
            $display("FAIL burst_ov: got ov=%b cnt=%h want ov=1 cnt=4", o0_ov, o0_cnt); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (o0_we !== 1'b1 || o0_data !== 8'(i)) begin errors++;
                $display("FAIL burst_order: got we=%b data=%h want we=1 data=%h", o0_we, o0_data, 8'(i)); end
            step(0, 0, 0, 1, 1);
        end
        checks++; if (o0_we !== 1'b0) begin errors++; $display("FAIL burst_empty: got %b want 0", o0_we); end
    endtask

    task automatic test_full_simul();
        logic [7:0] exp_seq [4];
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h33; exp_seq[2] = 8'h44; exp_seq[3] = 8'h99;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) step(1, 22'(i * 2), 8'(i * 17), 0, 1);
        checks++; if (o0_ov !== 1'b0) begin errors++; $display("FAIL full_pre_ov: got %b want 0", o0_ov); end
        step(1, 22'h000100, 8'h99, 1, 1);
        checks++; if (o0_ov !== 1'b0 || o0_we !== 1'b1 || o0_cnt !== 22'd5) begin errors++;
            $display("FAIL full_simul: got ov=%b we=%b cnt=%h want 0/1/5", o0_ov, o0_we, o0_cnt); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (o0_data !== exp_seq[i]) begin errors++;
                $display("FAIL full_order: got %h want %h", o0_data, exp_seq[i]); end
            step(0, 0, 0, 1, 1);
        end
        checks++; if (o0_we !== 1'b0) begin errors++; $display("FAIL full_empty: got %b want 0", o0_we); end
    endtask

    task automatic test_dl_end();
        int pulses;
        for (int i = 0; i < 6; i++) step(1, 22'(i), 8'(i + 8'h50), 0, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);
        checks++; if (o0_done !== 1'b0 || o0_we !== 1'b1) begin errors++;
            $display("FAIL end_fall: got done=%b we=%b want 0/1", o0_done, o0_we); end
        step(0, 0, 0, 1, 0);
        checks++; if (o0_done !== 1'b0) begin errors++; $display("FAIL end_first_ack: got %b want 0", o0_done); end
        step(0, 0, 0, 1, 0);
        checks++; if (o0_done !== 1'b1 || o0_we !== 1'b0) begin errors++;
            $display("FAIL end_done: got done=%b we=%b want 1/0", o0_done, o0_we); end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            if (o0_done === 1'b1) pulses++;
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL end_extra_pulses: got %0d want 0", pulses); end
        checks++; if (o0_ov !== 1'b1) begin errors++; $display("FAIL end_ov_kept: got %b want 1", o0_ov); end
        step(0, 0, 0, 0, 1);
        checks++; if (o0_ov !== 1'b0 || o0_cnt !== 22'd0) begin errors++;
            $display("FAIL end_restart: got ov=%b cnt=%h want 0/0", o0_ov, o0_cnt); end
        step(0, 0, 0, 0, 0);
        checks++; if (o0_done !== 1'b1) begin errors++; $display("FAIL end_empty_fall: got %b want 1", o0_done); end
        step(0, 0, 0, 0, 0);
        checks++; if (o0_done !== 1'b0) begin errors++; $display("FAIL end_empty_once: got %b want 0", o0_done); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step(1, 22'(i + 7), 8'(i + 8'hC0), 0, 1);
        checks++; if (o0_we !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got %b want 1", o0_we); end
        #2 rst = 1'b1;
        #1;
        checks++; if (o0_we !== 1'b0 || o0_addr !== 22'd0 || o0_data !== 8'd0 || o0_mask !== 2'b11) begin
            errors++;
            $display("FAIL rstmid_outs: got we=%b addr=%h data=%h mask=%b want 0/0/0/11",
                     o0_we, o0_addr, o0_data, o0_mask); end
        checks++; if (o0_cnt !== 22'd0 || o0_ov !== 1'b0 || o0_done !== 1'b0) begin errors++;
            $display("FAIL rstmid_status: got cnt=%h ov=%b done=%b want 0", o0_cnt, o0_ov, o0_done); end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1, 22'h000013, 8'h5A, 0, 1);
        checks++; if (o0_we !== 1'b1 || o0_data !== 8'h5A || o0_addr !== 22'h9 || o0_mask !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_push: got we=%b data=%h addr=%h mask=%b want 1/5a/000009/01",
                     o0_we, o0_data, o0_addr, o0_mask); end
    endtask

    task automatic test_random();
        bit dl = 1'b1;
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 39) == 0) dl = !dl;
            step($urandom_range(0, 1) == 1, 22'($urandom), 8'($urandom), $urandom_range(0, 2) == 0, dl);
            checks++; if (o0_we !== (q.size() != 0) || o1_we !== o0_we) begin errors++;
                $display("FAIL rand_we: got %b/%b want %b", o0_we, o1_we, q.size() != 0); end
            if (q.size() != 0) begin
                checks++;
                if (o0_addr !== waddr(q[0].a, 22'd0) || o1_addr !== waddr(q[0].a, OFF1) ||
                    o0_data !== q[0].d || o0_mask !== wmask(q[0].a)) begin
                    errors++;
                    $display("FAIL rand_head: got %h/%h/%h/%b want %h/%h/%h/%b", o0_addr, o1_addr,
                             o0_data, o0_mask, waddr(q[0].a, 22'd0), waddr(q[0].a, OFF1),
                             q[0].d, wmask(q[0].a));
                end
            end
            checks++; if (o0_done !== m_done || o0_ov !== m_ov || o0_cnt !== 22'(m_cnt)) begin errors++;
                $display("FAIL rand_status: got done=%b ov=%b cnt=%h want %b/%b/%h",
                         o0_done, o0_ov, o0_cnt, m_done, m_ov, 22'(m_cnt)); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_byte();
        test_offset_wrap();
        test_burst_overflow();
        test_full_simul();
        test_dl_end();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
